tlc5955_scheduler: RTL and testbench

Frame/config sequencer placed directly in front of `tlc5955_spi`. Decides when each SPI transfer starts and whether it carries control data or grayscale data. Also steers the SPI block's single `next_data` strobe and data word to either the config-word store or the pixel buffer. Paces frames from an internal period timer, gives pending configuration priority, and flags frames missed because the pixel buffer was not ready.

---
 rtl/tlc5955_scheduler_pkg.sv | 19 +
 rtl/tlc5955_scheduler_frame_timer.sv | 31 +++
 rtl/tlc5955_scheduler.sv | 131 +++++++++++++
 tb/tb_tlc5955_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc5955_scheduler_pkg.sv
// Shared types and constants for the TLC5955 frame/config scheduler.
// Holds the FSM encoding, transfer source, device word counts and a width helper.
package tlc5955_scheduler_pkg;

    typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;
    typedef enum logic {PIX = 1'b0, CFG = 1'b1} src_t;

    localparam int NumPixels      = 48;
    localparam int NumConfigWords = 24;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/tlc5955_scheduler_frame_timer.sv
// Free-running reload counter: tick is high for one cycle every Period clocks.
// Period of 0 or 1 means a slot every cycle.
module frame_timer
    import tlc5955_scheduler_pkg::*;
#(
    parameter int Period = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    if (Period <= 1) begin : g_every
        assign tick = 1'b1;
    end else begin : g_count
        localparam int W = clog2(Period);
        logic [W-1:0] count;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                count <= W'(Period - 1);
            else if (count == '0)
                count <= W'(Period - 1);
            else
                count <= count - 1'b1;
        end

        assign tick = (count == '0);
    end

endmodule

// File: rtl/tlc5955_scheduler.sv
// Decides when tlc5955_spi starts a transfer and whether it carries config or pixels;
// steers next_data/data between the config store and the pixel FIFO.
module tlc5955_scheduler
    import tlc5955_scheduler_pkg::*;
#(
    parameter int DaisyChain   = 1,
    parameter int FramePeriod  = 100000,
    parameter int ConfigRepeat = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        enable,
    input  logic                                        cfg_request,
    input  logic                                        frame_valid,
    output logic [clog2(NumConfigWords*DaisyChain)-1:0] cfg_addr,
    input  logic [15:0]                                 cfg_data,
    input  logic [15:0]                                 pix_data,
    output logic                                        pix_next,
    output logic                                        cfg_done,
    output logic                                        frame_done,
    output logic                                        frame_missed,
    output logic                                        spi_transfer,
    output logic                                        spi_config_bit,
    output logic [15:0]                                 spi_data,
    input  logic                                        spi_busy,
    input  logic                                        spi_next_data
);

    localparam int AddrW       = clog2(NumConfigWords * DaisyChain);
    localparam int LastAddr    = NumConfigWords * DaisyChain - 1;
    localparam int RepW        = clog2(ConfigRepeat);
    localparam bit BackToBack  = (FramePeriod == 0);

    state_t          state, state_nxt;
    src_t            src, src_nxt;
    logic [RepW-1:0] repeat_cnt, repeat_nxt;
    logic            cfg_pending, cfg_again, frame_due, tick;
    logic            take_cfg, take_pix, restart_cfg, last_cfg, active;

    frame_timer #(.Period(FramePeriod)) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        state_nxt   = state;
        src_nxt     = src;
        repeat_nxt  = repeat_cnt;
        take_cfg    = 1'b0;
        take_pix    = 1'b0;
        restart_cfg = 1'b0;
        last_cfg    = 1'b0;
        case (state)
            IDLE: if (enable) begin
                if (cfg_pending) begin
                    src_nxt    = CFG;
                    repeat_nxt = RepW'(ConfigRepeat - 1);
                    take_cfg   = 1'b1;
                    state_nxt  = START;
                end else if (frame_due && frame_valid) begin
                    src_nxt   = PIX;
                    take_pix  = 1'b1;
                    state_nxt = START;
                end
            end
            START: if (spi_busy) state_nxt = XFER;
            XFER:  if (!spi_busy) state_nxt = DONE;
            DONE: begin
                if (src == CFG && repeat_cnt != '0) begin
                    repeat_nxt  = repeat_cnt - 1'b1;
                    restart_cfg = 1'b1;
                    state_nxt   = START;
                end else begin
                    last_cfg  = (src == CFG);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Everything below decodes registered state, so reset clears it without waiting for a clock.
    assign active         = (state != IDLE);
    assign spi_transfer   = (state == START);
    assign spi_config_bit = (state == START) && (src == CFG);
    assign cfg_done       = (state == DONE) && (src == CFG) && (repeat_cnt == '0);
    assign frame_done     = (state == DONE) && (src == PIX);
    assign spi_data       = !active ? 16'h0 : (src == CFG) ? cfg_data : pix_data;
    assign pix_next       = active && (src == PIX) && spi_next_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            src          <= PIX;
            repeat_cnt   <= '0;
            cfg_addr     <= '0;
            cfg_pending  <= 1'b1;
            cfg_again    <= 1'b0;
            frame_due    <= 1'b0;
            frame_missed <= 1'b0;
        end else begin
            state      <= state_nxt;
            src        <= src_nxt;
            repeat_cnt <= repeat_nxt;

            if (take_cfg || restart_cfg)
                cfg_addr <= '0;
            else if (active && src == CFG && spi_next_data)
                cfg_addr <= (cfg_addr == AddrW'(LastAddr)) ? '0 : cfg_addr + 1'b1;

            // A request landing mid-config must survive the clear at the end of that sequence.
            if (last_cfg)
                cfg_pending <= cfg_again | cfg_request;
            else if (cfg_request)
                cfg_pending <= 1'b1;

            if (last_cfg)
                cfg_again <= 1'b0;
            else if (cfg_request && active && src == CFG)
                cfg_again <= 1'b1;

            frame_missed <= tick && frame_due && !take_pix && !BackToBack;
            if (tick)
                frame_due <= 1'b1;
            else if (take_pix)
                frame_due <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tlc5955_scheduler.sv
// Directed bench: two schedulers (back-to-back and 5000-cycle period), each driving a
// behavioural tlc5955_spi, config store and pixel FIFO.
module tb_tlc5955_scheduler;

    localparam int FP = 5000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic en  [2];
    logic req [2];
    logic fv  [2];
    int   ecount = 0;
    int   passed = 0;
    int   total  = 0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;

    for (genvar g = 0; g < 2; g++) begin : u
        logic        transfer, cfg_bit, busy, nxt, pix_next, cfg_done, frame_done, frame_missed;
        logic        cur_cfg;
        logic [15:0] spi_data, cfg_data, pix_data;
        logic [4:0]  cfg_addr;
        int remaining = 0, gap = 0, cfg_idx = 0, pix_pops = 0;
        int n_cfg_xfer = 0, n_pix_xfer = 0, n_cfg_adv = 0, n_pix_next = 0;
        int n_cfg_done = 0, n_frame_done = 0, n_missed = 0, n_data_err = 0;
        int kcount = 0, cd_stamp = 0;
        int klog [64];
        int kstamp [64];
        int fd_stamp [16];

        assign cfg_data = 16'hC000 | {11'b0, cfg_addr};
        assign pix_data = 16'h5000 + pix_pops[15:0];

        tlc5955_scheduler #(
            .DaisyChain   (1),
            .FramePeriod  ((g == 0) ? 0 : FP),
            .ConfigRepeat (2)
        ) dut (
            .clk            (clk),
            .reset          (rst_n),
            .enable         (en[g]),
            .cfg_request    (req[g]),
            .frame_valid    (fv[g]),
            .cfg_addr       (cfg_addr),
            .cfg_data       (cfg_data),
            .pix_data       (pix_data),
            .pix_next       (pix_next),
            .cfg_done       (cfg_done),
            .frame_done     (frame_done),
            .frame_missed   (frame_missed),
            .spi_transfer   (transfer),
            .spi_config_bit (cfg_bit),
            .spi_data       (spi_data),
            .spi_busy       (busy),
            .spi_next_data  (nxt)
        );

        // SPI model: busy the cycle after transfer, one next_data every 3 cycles, 24 or 48 words.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy      <= 1'b0;
                nxt       <= 1'b0;
                remaining <= 0;
                gap       <= 0;
                cur_cfg   <= 1'b0;
            end else begin
                nxt <= 1'b0;
                if (!busy) begin
                    if (transfer) begin
                        busy      <= 1'b1;
                        cur_cfg   <= cfg_bit;
                        remaining <= cfg_bit ? 24 : 48;
                        gap       <= 0;
                    end
                end else if (remaining == 0) begin
                    busy <= 1'b0;
                end else if (gap == 2) begin
                    nxt       <= 1'b1;
                    remaining <= remaining - 1;
                    gap       <= 0;
                end else begin
                    gap <= gap + 1;
                end
            end
        end

        always @(posedge clk) begin
            if (rst_n) begin
                if (!busy && transfer) begin
                    if (kcount < 64) begin
                        klog[kcount]   <= cfg_bit ? 1 : 2;
                        kstamp[kcount] <= ecount;
                    end
                    kcount  <= kcount + 1;
                    cfg_idx <= 0;
                    if (cfg_bit) n_cfg_xfer <= n_cfg_xfer + 1;
                    else         n_pix_xfer <= n_pix_xfer + 1;
                end
                if (nxt && cur_cfg) begin
                    n_cfg_adv <= n_cfg_adv + 1;
                    cfg_idx   <= cfg_idx + 1;
                    if (spi_data !== (16'hC000 | 16'(cfg_idx % 24))) n_data_err <= n_data_err + 1;
                end
                if (nxt && !cur_cfg && spi_data !== (16'h5000 + pix_pops[15:0]))
                    n_data_err <= n_data_err + 1;
                if (pix_next) begin
                    n_pix_next <= n_pix_next + 1;
                    pix_pops   <= pix_pops + 1;
                end
                if (cfg_done) begin
                    n_cfg_done <= n_cfg_done + 1;
                    cd_stamp   <= ecount;
                end
                if (frame_done) begin
                    if (n_frame_done < 16) fd_stamp[n_frame_done] <= ecount;
                    n_frame_done <= n_frame_done + 1;
                end
                if (frame_missed) n_missed <= n_missed + 1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin en[g] = 1'b0; req[g] = 1'b0; fv[g] = 1'b0; end
        cyc(3);
        total++; if (u[1].transfer !== 1'b0) $display("FAIL reset_transfer got %b want 0", u[1].transfer); else passed++;
        total++; if (u[1].cfg_addr !== 5'd0) $display("FAIL reset_cfg_addr got %0d want 0", u[1].cfg_addr); else passed++;
        total++; if (u[1].spi_data !== 16'h0) $display("FAIL reset_spi_data got %h want 0000", u[1].spi_data); else passed++;
        total++; if (u[1].frame_missed !== 1'b0) $display("FAIL reset_missed got %b want 0", u[1].frame_missed); else passed++;
        total++; if ({u[1].cfg_done, u[1].frame_done, u[1].pix_next, u[1].cfg_bit} !== 4'b0)
            $display("FAIL reset_pulses got %b want 0000", {u[1].cfg_done, u[1].frame_done, u[1].pix_next, u[1].cfg_bit});
        else passed++;
        rst_n = 1'b1;
        cyc(6);
        total++; if (u[0].kcount + u[1].kcount !== 0)
            $display("FAIL disabled_no_start got %0d transfers want 0", u[0].kcount + u[1].kcount);
        else passed++;
    endtask

    task automatic test_config_boot();
        en[0] = 1'b1;
        fv[0] = 1'b1;
        for (int i = 0; i < 3000 && u[0].n_frame_done == 0; i++) cyc(1);
        en[0] = 1'b0;
        fv[0] = 1'b0;
        total++; if (u[0].n_frame_done !== 1) $display("FAIL boot_frame_done got %0d want 1", u[0].n_frame_done); else passed++;
        total++; if (u[0].klog[0] * 100 + u[0].klog[1] * 10 + u[0].klog[2] !== 112)
            $display("FAIL boot_order got %0d%0d%0d want 112", u[0].klog[0], u[0].klog[1], u[0].klog[2]);
        else passed++;
        total++; if (u[0].n_cfg_xfer !== 2) $display("FAIL boot_cfg_xfers got %0d want 2", u[0].n_cfg_xfer); else passed++;
        total++; if (u[0].n_cfg_adv !== 48) $display("FAIL boot_cfg_adv got %0d want 48", u[0].n_cfg_adv); else passed++;
        total++; if (u[0].n_cfg_done !== 1) $display("FAIL boot_cfg_done got %0d want 1", u[0].n_cfg_done); else passed++;
        total++; if (u[0].n_pix_next !== 48) $display("FAIL boot_pix_next got %0d want 48", u[0].n_pix_next); else passed++;
        total++; if (u[0].cfg_addr !== 5'd0) $display("FAIL boot_addr_wrap got %0d want 0", u[0].cfg_addr); else passed++;
        total++; if (u[0].n_data_err !== 0) $display("FAIL boot_data got %0d bad words want 0", u[0].n_data_err); else passed++;
    endtask

    task automatic test_frames();
        en[1] = 1'b1;
        fv[1] = 1'b1;
        for (int i = 0; i < 4 * FP && u[1].n_frame_done < 3; i++) cyc(1);
        total++; if (u[1].n_frame_done !== 3) $display("FAIL frames_count got %0d want 3", u[1].n_frame_done); else passed++;
        total++; if (u[1].fd_stamp[1] - u[1].fd_stamp[0] !== FP)
            $display("FAIL frames_period1 got %0d want %0d", u[1].fd_stamp[1] - u[1].fd_stamp[0], FP);
        else passed++;
        total++; if (u[1].fd_stamp[2] - u[1].fd_stamp[1] !== FP)
            $display("FAIL frames_period2 got %0d want %0d", u[1].fd_stamp[2] - u[1].fd_stamp[1], FP);
        else passed++;
        total++; if (u[1].n_pix_next !== 144) $display("FAIL frames_pops got %0d want 144", u[1].n_pix_next); else passed++;
        total++; if (u[1].n_missed !== 0) $display("FAIL frames_missed got %0d want 0", u[1].n_missed); else passed++;
        total++; if (u[1].n_cfg_done !== 1) $display("FAIL frames_cfg_done got %0d want 1", u[1].n_cfg_done); else passed++;
        total++; if (u[1].n_data_err !== 0) $display("FAIL frames_data got %0d bad words want 0", u[1].n_data_err); else passed++;
    endtask

    task automatic test_missed();
        int m0, p0, f0;
        logic seen;
        fv[1] = 1'b0;
        m0 = u[1].n_missed;
        p0 = u[1].n_pix_xfer;
        f0 = u[1].n_frame_done;
        for (int i = 0; i < 3 * FP && u[1].n_missed == m0; i++) cyc(1);
        cyc(20);
        total++; if (u[1].n_missed - m0 !== 1) $display("FAIL missed_count got %0d want 1", u[1].n_missed - m0); else passed++;
        total++; if (u[1].n_pix_xfer !== p0) $display("FAIL missed_no_xfer got %0d want %0d", u[1].n_pix_xfer, p0); else passed++;
        fv[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin cyc(1); if (u[1].transfer === 1'b1) seen = 1'b1; end
        total++; if (seen !== 1'b1) $display("FAIL missed_late_start got %b want 1", seen); else passed++;
        for (int i = 0; i < 400 && u[1].n_frame_done == f0; i++) cyc(1);
        total++; if (u[1].n_frame_done - f0 !== 1) $display("FAIL missed_late_done got %0d want 1", u[1].n_frame_done - f0); else passed++;
    endtask

    task automatic test_cfg_collision();
        int slot, k0, m0, c0;
        slot = (ecount / FP + 1) * FP;
        for (int i = 0; i < FP + 10 && ecount != slot - 1; i++) cyc(1);
        req[1] = 1'b1;
        k0 = u[1].kcount;
        m0 = u[1].n_missed;
        c0 = u[1].n_cfg_done;
        cyc(1);
        req[1] = 1'b0;
        for (int i = 0; i < 1000 && u[1].kcount < k0 + 3; i++) cyc(1);
        total++; if (u[1].kcount - k0 !== 3) $display("FAIL coll_xfers got %0d want 3", u[1].kcount - k0); else passed++;
        total++; if (u[1].klog[k0] * 100 + u[1].klog[k0 + 1] * 10 + u[1].klog[k0 + 2] !== 112)
            $display("FAIL coll_order got %0d%0d%0d want 112", u[1].klog[k0], u[1].klog[k0 + 1], u[1].klog[k0 + 2]);
        else passed++;
        total++; if (u[1].n_cfg_done - c0 !== 1) $display("FAIL coll_cfg_done got %0d want 1", u[1].n_cfg_done - c0); else passed++;
        total++; if (u[1].kstamp[k0 + 2] - u[1].cd_stamp !== 2)
            $display("FAIL coll_pix_gap got %0d want 2", u[1].kstamp[k0 + 2] - u[1].cd_stamp);
        else passed++;
        total++; if (u[1].n_missed !== m0) $display("FAIL coll_missed got %0d want %0d", u[1].n_missed, m0); else passed++;
        for (int i = 0; i < 400 && u[1].busy !== 1'b0; i++) cyc(1);
    endtask

    task automatic test_enable_mid();
        int p0, f0, k0, slot;
        logic seen;
        p0 = u[1].n_pix_xfer;
        f0 = u[1].n_frame_done;
        for (int i = 0; i < FP + 500 && u[1].n_pix_xfer == p0; i++) cyc(1);
        cyc(10);
        en[1] = 1'b0;
        for (int i = 0; i < 400 && u[1].n_frame_done == f0; i++) cyc(1);
        total++; if (u[1].n_frame_done - f0 !== 1) $display("FAIL en_mid_done got %0d want 1", u[1].n_frame_done - f0); else passed++;
        k0 = u[1].kcount;
        slot = (ecount / FP + 1) * FP;
        for (int i = 0; i < FP + 100 && ecount < slot + 10; i++) cyc(1);
        total++; if (u[1].kcount !== k0) $display("FAIL en_off_start got %0d want %0d", u[1].kcount, k0); else passed++;
        en[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin cyc(1); if (u[1].transfer === 1'b1) seen = 1'b1; end
        total++; if (seen !== 1'b1) $display("FAIL en_on_start got %b want 1", seen); else passed++;
    endtask

    task automatic test_reset_mid();
        int k0;
        for (int i = 0; i < 20 && u[1].busy !== 1'b1; i++) cyc(1);
        cyc(10);
        total++; if (u[1].spi_data === 16'h0) $display("FAIL rmid_active_data got %h want nonzero", u[1].spi_data); else passed++;
        k0 = u[1].kcount;
        rst_n = 1'b0;
        #1;
        total++; if (u[1].spi_data !== 16'h0) $display("FAIL rmid_spi_data got %h want 0000", u[1].spi_data); else passed++;
        total++; if (u[1].cfg_addr !== 5'd0) $display("FAIL rmid_cfg_addr got %0d want 0", u[1].cfg_addr); else passed++;
        total++; if ({u[1].transfer, u[1].cfg_bit, u[1].pix_next} !== 3'b0)
            $display("FAIL rmid_spi_ctrl got %b want 000", {u[1].transfer, u[1].cfg_bit, u[1].pix_next});
        else passed++;
        total++; if ({u[1].cfg_done, u[1].frame_done, u[1].frame_missed} !== 3'b0)
            $display("FAIL rmid_pulses got %b want 000", {u[1].cfg_done, u[1].frame_done, u[1].frame_missed});
        else passed++;
        cyc(2);
        rst_n = 1'b1;
        for (int i = 0; i < 50 && u[1].kcount == k0; i++) cyc(1);
        total++; if (u[1].kcount - k0 !== 1) $display("FAIL rmid_restart got %0d want 1", u[1].kcount - k0); else passed++;
        total++; if (u[1].klog[k0] !== 1) $display("FAIL rmid_cfg_first got kind %0d want 1", u[1].klog[k0]); else passed++;
    endtask

    initial begin
        test_reset();
        test_config_boot();
        test_frames();
        test_missed();
        test_cfg_collision();
        test_enable_mid();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
